nibble_serial_adder_ctrl: RTL and testbench
===========================================

Name: nibble_serial_adder_ctrl

Overview:
- Sequencer that wraps the 4-bit ripple-carry adder slice to add two WIDTH-bit operands one nibble per cycle, least-significant nibble first.
- Upstream of the slice: drives the slice's A, B and CIN. Downstream of the slice: captures SUM and COUT each cycle and chains COUT[3] into the next nibble's CIN.
- Operands arrive on a valid/ready input handshake. The result leaves on a valid/ready output handshake.
- The slice is instantiated outside this block, alongside it.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 4.
- NIB, WIDTH/4, number of nibble steps. Derived; must not be overridden.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand set valid.
- in_ready  out  1  block can accept an operand set.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry into nibble 0.
- add_a  out  4  nibble of A driven to the slice.
- add_b  out  4  nibble of B driven to the slice.
- add_cin  out  1  carry driven to the slice.
- add_sum  in  4  slice SUM.
- add_cout  in  4  slice COUT[3:0] (per-bit carries).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_sum  out  WIDTH  result sum.
- out_cout  out  1  final carry out.
- out_ovf  out  1  two's-complement overflow.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values:
  - state=IDLE; all operand, result and carry registers = 0; nibble counter = 0.
  - out_valid=0, out_sum=0, out_cout=0, out_ovf=0, in_ready=1.
- FSM states: IDLE, RUN, DONE.
- in_ready = (state==IDLE), decoded from state, not from in_valid. out_valid = (state==DONE).
- IDLE:
  - On in_valid & in_ready, latch in_a, in_b; latch carry_reg<=in_cin; cnt<=0; go to RUN.
  - Otherwise stay in IDLE.
- RUN (exactly NIB cycles):
  - Drive add_a=a_reg[4*cnt+3:4*cnt], add_b=b_reg[4*cnt+3:4*cnt], add_cin=carry_reg. These are combinational from the registers.
  - Each edge: sum_reg[4*cnt+3:4*cnt]<=add_sum; carry_reg<=add_cout[3]; cnt<=cnt+1.
  - On the edge where cnt==NIB-1: out_cout<=add_cout[3]; out_ovf<=add_cout[3]^add_cout[2]; cnt<=0; go to DONE.
- Outside RUN: add_a, add_b and add_cin are driven 0.
- DONE:
  - Hold out_sum, out_cout and out_ovf stable.
  - On out_ready, go to IDLE. Result registers keep their values until the next accept overwrites them.
- Latency: accept on edge T gives out_valid=1 after edge T+NIB.
- Throughput: with out_ready held high, one operation every NIB+2 cycles. There is no overlap: in_ready=0 during RUN and DONE.
- in_valid while busy is ignored; the operands are not sampled.
- Input changes after accept have no effect; operands are registered.
- out_ready while not in DONE is ignored.
- Wrap-around:
  - out_sum = (A+B+cin) mod 2^WIDTH.
  - out_cout = bit WIDTH of the full sum.
  - out_ovf = signed overflow of the WIDTH-bit add.
- WIDTH=4: single RUN cycle; behaviour is identical to a direct slice add, registered.
- Reset mid-operation (RUN or DONE): all state returns to reset values immediately (asynchronous). A partial result is never emitted. in_ready=1 on the first cycle after rst_n deasserts.

Test Plan (WIDTH=16):
- 0x1234 + 0x4321, cin=0 -> after 4 RUN cycles out_valid=1, out_sum=0x5555, out_cout=0, out_ovf=0. Slice is driven add_a=4,3,2,1 in that order.
- 0xFFFF + 0x0001, cin=0 -> out_sum=0x0000, out_cout=1, out_ovf=0. add_cin is 0,1,1,1 across the nibbles.
- 0x7FFF + 0x0001, cin=0 -> out_sum=0x8000, out_cout=0, out_ovf=1. Separately, 0x0000 + 0x0000 with cin=1 -> out_sum=0x0001.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0 throughout. A new in_valid pulse during those cycles is not accepted. Raising out_ready returns to IDLE next edge.
- Back-to-back: in_valid held high with out_ready=1 -> successive accepts exactly NIB+2 = 6 cycles apart, each result correct.
- Assert rst_n=0 in RUN at cnt=2 -> out_valid never rises. After release, in_ready=1, out_sum=0, and a fresh add 0x0F0F+0x0101 yields 0x1010.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl.sv
// rtl/nibble_serial_adder_ctrl.sv - nibble-serial sequencer around an external 4-bit ripple-carry slice
//
// Ports:
//   clk, rst_n                       clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready                operand handshake; in_a, in_b (WIDTH), in_cin
//   add_a, add_b, add_cin            nibble operands and carry driven to the slice
//   add_sum, add_cout                slice sum and per-bit carries returned
//   out_valid/out_ready              result handshake; out_sum (WIDTH), out_cout, out_ovf

module nibble_serial_adder_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   output logic [3:0]       add_a,
   output logic [3:0]       add_b,
   output logic             add_cin,
   input  logic [3:0]       add_sum,
   input  logic [3:0]       add_cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf
);

   localparam int NIB = WIDTH / 4;
   localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [CW-1:0] LAST = CW'(NIB - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] sum_reg;
   logic             carry_reg;
   logic             cout_reg;
   logic             ovf_reg;
   logic [CW-1:0]    cnt;
   logic             accept;
   logic             last_nib;

   assign accept   = in_valid && (state == IDLE);
   assign last_nib = (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      add_a      = 4'd0;
      add_b      = 4'd0;
      add_cin    = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_next = RUN;
            end
         end
         RUN: begin
            add_a   = a_reg[{cnt, 2'b00} +: 4];
            add_b   = b_reg[{cnt, 2'b00} +: 4];
            add_cin = carry_reg;
            if (last_nib) begin
               state_next = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath registers. sum_reg is rebuilt nibble by nibble during RUN; it is
   // only exposed as a valid result once DONE is reached, so the partially
   // updated value seen during RUN is never handed downstream.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg     <= '0;
         b_reg     <= '0;
         sum_reg   <= '0;
         carry_reg <= 1'b0;
         cout_reg  <= 1'b0;
         ovf_reg   <= 1'b0;
         cnt       <= '0;
      end else begin
         if (accept) begin
            a_reg     <= in_a;
            b_reg     <= in_b;
            carry_reg <= in_cin;
            cnt       <= '0;
         end else if (state == RUN) begin
            sum_reg[{cnt, 2'b00} +: 4] <= add_sum;
            carry_reg                  <= add_cout[3];
            if (last_nib) begin
               cout_reg <= add_cout[3];
               // Signed overflow: carry into the sign bit differs from carry out.
               ovf_reg  <= add_cout[3] ^ add_cout[2];
               cnt      <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

   assign out_sum  = sum_reg;
   assign out_cout = cout_reg;
   assign out_ovf  = ovf_reg;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb/tb_nibble_serial_adder_ctrl.sv - directed self-checking bench for nibble_serial_adder_ctrl

module tb_nibble_serial_adder_ctrl;

   localparam int WIDTH = 16;
   localparam int NIB   = WIDTH / 4;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic [3:0]       add_a;
   logic [3:0]       add_b;
   logic             add_cin;
   logic [3:0]       add_sum;
   logic [3:0]       add_cout;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic             out_ovf;

   int checks;
   int errors;

   nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_a     (in_a),
      .in_b     (in_b),
      .in_cin   (in_cin),
      .add_a    (add_a),
      .add_b    (add_b),
      .add_cin  (add_cin),
      .add_sum  (add_sum),
      .add_cout (add_cout),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_sum  (out_sum),
      .out_cout (out_cout),
      .out_ovf  (out_ovf)
   );

   // Behavioural model of the external 4-bit ripple-carry slice.
   always_comb begin
      logic c;
      add_sum  = 4'd0;
      add_cout = 4'd0;
      c        = add_cin;
      for (int i = 0; i < 4; i++) begin
         add_sum[i]  = add_a[i] ^ add_b[i] ^ c;
         c           = (add_a[i] & add_b[i]) | (add_a[i] & c) | (add_b[i] & c);
         add_cout[i] = c;
      end
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Accept one operand set, step through RUN, stop at the negedge after the
   // last RUN edge (where DONE should be visible). Records what the slice saw.
   task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                         output logic [WIDTH-1:0] seen_a, output logic [NIB-1:0] seen_cin,
                         output logic early_valid, output logic valid_at_end);
      @(negedge clk);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_cin   = cin;
      @(posedge clk);
      #1 in_valid = 1'b0;
      early_valid = 1'b0;
      seen_a      = '0;
      seen_cin    = '0;
      for (int i = 0; i < NIB; i++) begin
         @(negedge clk);
         seen_a[4*i +: 4] = add_a;
         seen_cin[i]      = add_cin;
         early_valid      = early_valid | out_valid;
      end
      @(negedge clk);
      valid_at_end = out_valid;
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++;
      if ({out_sum, out_cout, out_ovf} !== '0) begin
         errors++; $display("FAIL reset_outputs: got sum=%h cout=%b ovf=%b expected all 0", out_sum, out_cout, out_ovf);
      end
      checks++;
      if ({add_a, add_b, add_cin} !== 9'd0) begin
         errors++; $display("FAIL reset_slice_drive: got a=%h b=%h cin=%b expected 0", add_a, add_b, add_cin);
      end
   endtask

   task automatic test_basic();
      logic [WIDTH-1:0] sa;
      logic [NIB-1:0]   sc;
      logic             early, vend;
      run_op(16'h1234, 16'h4321, 1'b0, sa, sc, early, vend);
      checks++;
      if (early !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b expected 0", early); end
      checks++;
      if (vend !== 1'b1) begin errors++; $display("FAIL basic_latency: out_valid got %b expected 1", vend); end
      checks++;
      if (sa !== 16'h1234) begin errors++; $display("FAIL basic_add_a_order: got nibbles %h expected 1234 (4,3,2,1 lsn first)", sa); end
      checks++;
      if ({out_sum, out_cout, out_ovf} !== {16'h5555, 1'b0, 1'b0}) begin
         errors++; $display("FAIL basic_result: got sum=%h cout=%b ovf=%b expected 5555 0 0", out_sum, out_cout, out_ovf);
      end
      release_result();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++; $display("FAIL basic_return_idle: got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_carry_chain();
      logic [WIDTH-1:0] sa;
      logic [NIB-1:0]   sc;
      logic             early, vend;
      run_op(16'hFFFF, 16'h0001, 1'b0, sa, sc, early, vend);
      checks++;
      if (sc !== 4'b1110) begin errors++; $display("FAIL carry_add_cin_seq: got %b expected 1110 (0,1,1,1 lsn first)", sc); end
      checks++;
      if ({vend, out_sum, out_cout, out_ovf} !== {1'b1, 16'h0000, 1'b1, 1'b0}) begin
         errors++; $display("FAIL carry_result: got valid=%b sum=%h cout=%b ovf=%b expected 1 0000 1 0", vend, out_sum, out_cout, out_ovf);
      end
      release_result();
   endtask

   task automatic test_overflow();
      logic [WIDTH-1:0] sa;
      logic [NIB-1:0]   sc;
      logic             early, vend;
      run_op(16'h7FFF, 16'h0001, 1'b0, sa, sc, early, vend);
      checks++;
      if ({vend, out_sum, out_cout, out_ovf} !== {1'b1, 16'h8000, 1'b0, 1'b1}) begin
         errors++; $display("FAIL ovf_result: got valid=%b sum=%h cout=%b ovf=%b expected 1 8000 0 1", vend, out_sum, out_cout, out_ovf);
      end
      release_result();
      run_op(16'h0000, 16'h0000, 1'b1, sa, sc, early, vend);
      checks++;
      if ({vend, out_sum, out_cout, out_ovf} !== {1'b1, 16'h0001, 1'b0, 1'b0}) begin
         errors++; $display("FAIL cin_result: got valid=%b sum=%h cout=%b ovf=%b expected 1 0001 0 0", vend, out_sum, out_cout, out_ovf);
      end
      release_result();
   endtask

   task automatic test_backpressure();
      logic [WIDTH-1:0] sa;
      logic [NIB-1:0]   sc;
      logic             early, vend;
      int               bad;
      run_op(16'h1234, 16'h4321, 1'b0, sa, sc, early, vend);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         if (i == 1) begin
            in_valid = 1'b1;
            in_a     = 16'hAAAA;
            in_b     = 16'h1111;
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clk);
         @(negedge clk);
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 16'h5555 || out_cout !== 1'b0 || out_ovf !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold cycle %0d: got valid=%b in_ready=%b sum=%h cout=%b ovf=%b expected 1 0 5555 0 0",
                     i, out_valid, in_ready, out_sum, out_cout, out_ovf);
         end
      end
      checks++;
      if (bad != 0) errors++;
      in_valid = 1'b0;
      release_result();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 16'h5555) begin
         errors++; $display("FAIL bp_release: got in_ready=%b out_valid=%b sum=%h expected 1 0 5555", in_ready, out_valid, out_sum);
      end
   endtask

   task automatic test_back_to_back();
      logic [WIDTH-1:0] va [3];
      logic [WIDTH-1:0] vb [3];
      logic             vc [3];
      logic [WIDTH+1:0] exp_r [3];
      int               acc_cyc [3];
      int               n_acc, n_res, cyc;
      va[0] = 16'h0001; vb[0] = 16'h0002; vc[0] = 1'b0; exp_r[0] = {16'h0003, 1'b0, 1'b0};
      va[1] = 16'h8000; vb[1] = 16'h8000; vc[1] = 1'b0; exp_r[1] = {16'h0000, 1'b1, 1'b1};
      va[2] = 16'h00FF; vb[2] = 16'h0F01; vc[2] = 1'b1; exp_r[2] = {16'h1001, 1'b0, 1'b0};
      n_acc = 0; n_res = 0; cyc = 0;
      out_ready = 1'b1;
      while (n_res < 3 && cyc < 60) begin
         if (out_valid === 1'b1) begin
            checks++;
            if (n_res >= 3 || {out_sum, out_cout, out_ovf} !== exp_r[n_res]) begin
               errors++; $display("FAIL b2b_result %0d: got %h/%b/%b expected %h", n_res, out_sum, out_cout, out_ovf, exp_r[n_res]);
            end
            n_res++;
         end
         if (n_acc < 3) begin
            in_valid = 1'b1;
            in_a     = va[n_acc];
            in_b     = vb[n_acc];
            in_cin   = vc[n_acc];
            if (in_ready === 1'b1) begin
               acc_cyc[n_acc] = cyc;
               n_acc++;
            end
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clk);
         @(negedge clk);
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      checks++;
      if (n_res != 3 || n_acc != 3) begin
         errors++; $display("FAIL b2b_timeout: got %0d accepts %0d results expected 3 3", n_acc, n_res);
      end else begin
         checks++;
         if (acc_cyc[1] - acc_cyc[0] != NIB + 2 || acc_cyc[2] - acc_cyc[1] != NIB + 2) begin
            errors++; $display("FAIL b2b_spacing: got %0d,%0d expected %0d", acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1], NIB + 2);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_run();
      logic [WIDTH-1:0] sa;
      logic [NIB-1:0]   sc;
      logic             early, vend, seen_valid;
      @(negedge clk);
      in_valid = 1'b1;
      in_a     = 16'h3210;
      in_b     = 16'h1111;
      in_cin   = 1'b0;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      checks++;
      if (add_a !== 4'h2) begin errors++; $display("FAIL rst_mid_cnt2: add_a got %h expected 2", add_a); end
      rst_n = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || add_a !== 4'h0) begin
         errors++; $display("FAIL rst_mid_async: got in_ready=%b out_valid=%b add_a=%h expected 1 0 0", in_ready, out_valid, add_a);
      end
      seen_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         seen_valid = seen_valid | out_valid;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         seen_valid = seen_valid | out_valid;
      end
      checks++;
      if (seen_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_no_emit: out_valid got %b expected 0", seen_valid); end
      checks++;
      if (in_ready !== 1'b1 || out_sum !== 16'h0000 || out_cout !== 1'b0) begin
         errors++; $display("FAIL rst_mid_after: got in_ready=%b sum=%h cout=%b expected 1 0000 0", in_ready, out_sum, out_cout);
      end
      run_op(16'h0F0F, 16'h0101, 1'b0, sa, sc, early, vend);
      checks++;
      if ({vend, out_sum, out_cout, out_ovf} !== {1'b1, 16'h1010, 1'b0, 1'b0}) begin
         errors++; $display("FAIL rst_mid_fresh: got valid=%b sum=%h cout=%b ovf=%b expected 1 1010 0 0", vend, out_sum, out_cout, out_ovf);
      end
      release_result();
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_cin    = 1'b0;
      out_ready = 1'b0;
      #12;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      test_basic();
      test_carry_chain();
      test_overflow();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
